// File: rtl/sss_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : sss_generator_if
// Purpose  : Request/stream/error bundle between the SSS generator and its peers.
// Revision : 1.0 - initial release
// ============================================================================
interface sss_generator_if;
    logic [10:0] s_axis_in_tdata;
    logic        s_axis_in_tvalid;
    logic        s_axis_in_tready;
    logic        m_axis_out_tdata;
    logic        m_axis_out_tvalid;
    logic        m_axis_out_tready;
    logic        m_axis_out_tlast;
    logic        error_o;

    modport slave (
        input  s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
        output s_axis_in_tready, m_axis_out_tdata, m_axis_out_tvalid,
               m_axis_out_tlast, error_o
    );

    modport master (
        output s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
        input  s_axis_in_tready, m_axis_out_tdata, m_axis_out_tvalid,
               m_axis_out_tlast, error_o
    );
endinterface
`default_nettype wire

// File: rtl/sss_generator.sv
`default_nettype none
// ============================================================================
// Module   : sss_generator
// Purpose  : Streams the 127-bit NR SSS for (N_id_1, N_id_2), one bit per beat.
//            Define SSS_GEN_ROM_EN to hold the m-sequences as constants (no INIT).
// Revision : 1.0 - initial release
// ============================================================================
module sss_generator #(
    parameter int N_ID_1_MAX = 335,
    parameter int SHIFT_MAX  = 112
) (
    input  wire logic      clk_i,
    input  wire logic      reset_ni,
    sss_generator_if.slave bus
);
    localparam int         SSS_LEN = 127;
    localparam logic [6:0] c_LAST  = 7'(SSS_LEN - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_CALC   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [8:0]   r_nid1;
    logic [1:0]   r_nid2;
    logic [6:0]   r_p0;
    logic [6:0]   r_p1;
    logic [6:0]   r_n;
    logic         r_error;
    logic         r_alive;
    logic [126:0] w_mseq0;
    logic [126:0] w_mseq1;
    logic         w_fill_done;
    logic         w_req_take;
    logic         w_req_bad;
    logic         w_stream;
    logic         w_beat;
    logic [1:0]   w_q;
    logic [6:0]   w_m0;
    logic [6:0]   w_m1;

    function automatic logic [6:0] f_wrap_inc(input logic [6:0] p);
        return (p == c_LAST) ? 7'd0 : p + 7'd1;
    endfunction

`ifdef SSS_GEN_ROM_EN
    // Unrolls x(i+7) = x(i+TAP) ^ x(i) from x(6:0) = 0000001 at elaboration.
    function automatic logic [126:0] f_mseq(input int TAP);
        logic [133:0] v_x;
        v_x    = '0;
        v_x[0] = 1'b1;
        for (int i = 0; i < SSS_LEN; i++) begin
            v_x[i + 7] = v_x[i + TAP] ^ v_x[i];
        end
        return v_x[126:0];
    endfunction

    localparam logic [126:0] c_MSEQ_0      = f_mseq(4);
    localparam logic [126:0] c_MSEQ_1      = f_mseq(1);
    localparam state_t       c_RESET_STATE = ST_IDLE;

    assign w_mseq0     = c_MSEQ_0;
    assign w_mseq1     = c_MSEQ_1;
    assign w_fill_done = 1'b1;
`else
    localparam state_t c_RESET_STATE = ST_INIT;

    logic [126:0] r_mseq0;
    logic [126:0] r_mseq1;
    logic [6:0]   r_lfsr0;
    logic [6:0]   r_lfsr1;
    logic [6:0]   r_fill_idx;
    logic         r_filled;

    // Bit k of each LFSR holds x(i+k); bit 0 is the sample written this cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_mseq0    <= '0;
            r_mseq1    <= '0;
            r_lfsr0    <= 7'd1;
            r_lfsr1    <= 7'd1;
            r_fill_idx <= 7'd0;
            r_filled   <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_mseq0[r_fill_idx] <= r_lfsr0[0];
            r_mseq1[r_fill_idx] <= r_lfsr1[0];
            r_lfsr0             <= {r_lfsr0[4] ^ r_lfsr0[0], r_lfsr0[6:1]};
            r_lfsr1             <= {r_lfsr1[1] ^ r_lfsr1[0], r_lfsr1[6:1]};
            r_fill_idx          <= r_fill_idx + 7'd1;
            if (r_fill_idx == c_LAST) begin
                r_filled <= 1'b1;
            end
        end
    end

    assign w_mseq0     = r_mseq0;
    assign w_mseq1     = r_mseq1;
    assign w_fill_done = r_filled;
`endif

    assign w_stream   = (r_state == ST_STREAM);
    assign w_beat     = w_stream & bus.m_axis_out_tready;
    assign w_req_take = bus.s_axis_in_tready & bus.s_axis_in_tvalid;
    assign w_req_bad  = (bus.s_axis_in_tdata[10:2] > 9'(N_ID_1_MAX)) |
                        (bus.s_axis_in_tdata[1:0] == 2'd3);

    assign w_q  = (r_nid1 >= 9'(2 * SHIFT_MAX)) ? 2'd2 :
                  (r_nid1 >= 9'(SHIFT_MAX))     ? 2'd1 : 2'd0;
    assign w_m0 = ((w_q == 2'd2) ? 7'd30 : (w_q == 2'd1) ? 7'd15 : 7'd0) +
                  7'(r_nid2) * 7'd5;
    // Result is below SHIFT_MAX, so 7-bit modular subtraction is exact.
    assign w_m1 = r_nid1[6:0] - ((w_q == 2'd2) ? 7'(2 * SHIFT_MAX) :
                                 (w_q == 2'd1) ? 7'(SHIFT_MAX) : 7'd0);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
`ifndef SSS_GEN_ROM_EN
            ST_INIT:   if (r_fill_idx == c_LAST) w_state_nxt = ST_IDLE;
`endif
            ST_IDLE:   if (w_req_take && !w_req_bad) w_state_nxt = ST_CALC;
            ST_CALC:   w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_beat && (r_n == c_LAST)) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = w_fill_done ? ST_IDLE : ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_nid1  <= 9'd0;
            r_nid2  <= 2'd0;
            r_p0    <= 7'd0;
            r_p1    <= 7'd0;
            r_n     <= 7'd0;
            r_error <= 1'b0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_error <= w_req_take & w_req_bad;
            if (w_req_take) begin
                r_nid1 <= bus.s_axis_in_tdata[10:2];
                r_nid2 <= bus.s_axis_in_tdata[1:0];
            end
            if (r_state == ST_CALC) begin
                r_p0 <= w_m0;
                r_p1 <= w_m1;
                r_n  <= 7'd0;
            end else if (w_beat) begin
                r_p0 <= f_wrap_inc(r_p0);
                r_p1 <= f_wrap_inc(r_p1);
                r_n  <= r_n + 7'd1;
            end
        end
    end

    // r_alive keeps tready low while reset is held, even when reset lands in IDLE.
    assign bus.s_axis_in_tready  = (r_state == ST_IDLE) & r_alive;
    assign bus.m_axis_out_tvalid = w_stream;
    assign bus.m_axis_out_tdata  = w_stream & (w_mseq0[r_p0] ^ w_mseq1[r_p1]);
    assign bus.m_axis_out_tlast  = w_stream & (r_n == c_LAST);
    assign bus.error_o           = r_error;
endmodule
`default_nettype wire

// File: tb/tb_sss_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sss_generator
// Purpose  : Randomized self-checking bench for sss_generator against an SSS model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sss_generator;
    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    bit   x0[0:126];
    bit   x1[0:126];

    always #5 clk_i = ~clk_i;

    sss_generator_if u_if ();

    sss_generator u_dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (u_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_bit(input int nid1, input int nid2, input int k);
        int q, m0, m1;
        q  = nid1 / 112;
        m0 = 15 * q + 5 * nid2;
        m1 = nid1 % 112;
        return x0[(k + m0) % 127] ^ x1[(k + m1) % 127];
    endfunction

    task automatic release_and_wait(input int exp_edges);
        int cnt = 0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        while (cnt < 400) begin
            @(posedge clk_i);
            #1;
            cnt++;
            if (u_if.s_axis_in_tready) break;
        end
        chk("ready_after_reset", cnt, exp_edges);
    endtask

    // edges counts clock edges after the handshake edge; first tvalid follows 1 edge.
    task automatic run_req(input int nid1, input int nid2, input bit rnd, input int abort_at);
        int       k = 0;
        int       edges = 0;
        int       first = -1;
        bit       stalled = 1'b0;
        logic     pd = 1'b0;
        logic     pl = 1'b0;
        logic [8:0] v_n1;
        logic [1:0] v_n2;
        v_n1 = nid1[8:0];
        v_n2 = nid2[1:0];
        @(negedge clk_i);
        chk("req_tready", u_if.s_axis_in_tready, 1);
        u_if.s_axis_in_tdata  = {v_n1, v_n2};
        u_if.s_axis_in_tvalid = 1'b1;
        @(posedge clk_i);
        #1;
        u_if.s_axis_in_tvalid = 1'b0;
        u_if.s_axis_in_tdata  = '0;
        while (k < 127 && edges < 3000) begin
            @(negedge clk_i);
            u_if.m_axis_out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (u_if.m_axis_out_tvalid) begin
                if (first < 0) first = edges;
                if (stalled) begin
                    chk("stall_tdata", u_if.m_axis_out_tdata, pd);
                    chk("stall_tlast", u_if.m_axis_out_tlast, pl);
                end
                if (u_if.m_axis_out_tready) begin
                    chk($sformatf("tdata n1=%0d n2=%0d k=%0d", nid1, nid2, k),
                        u_if.m_axis_out_tdata, ref_bit(nid1, nid2, k));
                    chk($sformatf("tlast k=%0d", k), u_if.m_axis_out_tlast, (k == 126));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = u_if.m_axis_out_tdata;
                    pl = u_if.m_axis_out_tlast;
                end
            end
            edges++;
            if (abort_at >= 0 && k == abort_at) return;
        end
        u_if.m_axis_out_tready = 1'b1;
        chk("beat_count", k, 127);
        chk("first_valid_edge", first, 1);
        @(negedge clk_i);
        #1;
        chk("tvalid_after_last", u_if.m_axis_out_tvalid, 0);
        chk("tready_after_last", u_if.s_axis_in_tready, 1);
        if (!rnd) chk("tready_return_edge", edges, 128);
    endtask

    task automatic err_req(input int nid1, input int nid2);
        int pulses = 0;
        int vcnt = 0;
        logic [8:0] v_n1;
        logic [1:0] v_n2;
        v_n1 = nid1[8:0];
        v_n2 = nid2[1:0];
        @(negedge clk_i);
        u_if.s_axis_in_tdata  = {v_n1, v_n2};
        u_if.s_axis_in_tvalid = 1'b1;
        @(posedge clk_i);
        #1;
        u_if.s_axis_in_tvalid = 1'b0;
        u_if.s_axis_in_tdata  = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            #1;
            if (u_if.error_o) pulses++;
            if (u_if.m_axis_out_tvalid) vcnt++;
        end
        chk($sformatf("err_pulses n1=%0d n2=%0d", nid1, nid2), pulses, 1);
        chk("err_no_tvalid", vcnt, 0);
        chk("err_tready", u_if.s_axis_in_tready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bnd[4];
        int exp_init;
        for (int i = 0; i < 7; i++) begin
            x0[i] = (i == 0);
            x1[i] = (i == 0);
        end
        for (int i = 0; i < 120; i++) begin
            x0[i + 7] = x0[i + 4] ^ x0[i];
            x1[i + 7] = x1[i + 1] ^ x1[i];
        end
`ifdef SSS_GEN_ROM_EN
        exp_init = 1;
`else
        exp_init = 127;
`endif
        u_if.s_axis_in_tdata   = '0;
        u_if.s_axis_in_tvalid  = 1'b0;
        u_if.m_axis_out_tready = 1'b1;

        #23;
        chk("rst_tready", u_if.s_axis_in_tready, 0);
        chk("rst_tvalid", u_if.m_axis_out_tvalid, 0);
        chk("rst_tdata", u_if.m_axis_out_tdata, 0);
        chk("rst_tlast", u_if.m_axis_out_tlast, 0);
        chk("rst_error", u_if.error_o, 0);
        release_and_wait(exp_init);

        run_req(0, 0, 1'b0, -1);
        run_req(335, 2, 1'b0, -1);
        bnd = '{111, 112, 223, 224};
        for (int i = 0; i < 4; i++) run_req(bnd[i], i % 3, 1'b0, -1);

        err_req(336, 0);
        err_req(5, 3);
        err_req(511, 1);

        for (int i = 0; i < 20; i++) begin
            run_req(int'($urandom_range(0, 335)), int'($urandom_range(0, 2)), 1'b1, -1);
        end

        run_req(200, 1, 1'b0, 60);
        @(posedge clk_i);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("abort_tvalid", u_if.m_axis_out_tvalid, 0);
        chk("abort_tdata", u_if.m_axis_out_tdata, 0);
        chk("abort_tlast", u_if.m_axis_out_tlast, 0);
        chk("abort_tready", u_if.s_axis_in_tready, 0);
        chk("abort_error", u_if.error_o, 0);
        repeat (3) @(posedge clk_i);
        release_and_wait(exp_init);
        run_req(200, 1, 1'b0, -1);
        run_req(335, 0, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
